// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if: host write port and uart_tx issue port of the transmit buffer
interface uart_tx_buffer_if #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 4
);
   logic [DWIDTH-1:0] wr_data;
   logic              wr_en;
   logic              flush;
   logic              full;
   logic              empty;
   logic [AWIDTH:0]   count;
   logic              overflow;
   logic [DWIDTH-1:0] p_data;
   logic              data_valid;
   logic              busy;
   modport master(output wr_data, wr_en, flush, busy, input full, empty, count, overflow, p_data, data_valid);
   modport slave(input wr_data, wr_en, flush, busy, output full, empty, count, overflow, p_data, data_valid);
endinterface

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO that feeds uart_tx one byte per frame, paced by busy
module uart_tx_buffer #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 16,
   parameter int AWIDTH = 4
) (
   input logic clk,
   input logic rst,
   uart_tx_buffer_if.slave bus
);
   localparam int CW = AWIDTH + 1;
   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
   state_t            state;
   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH-1:0] wr_ptr, rd_ptr;
   logic              wr_ok, pop;
   logic [CW-1:0]     count_nxt;
   assign wr_ok = bus.wr_en & ~bus.full & ~bus.flush;
   // an issue is the pop; flush suppresses it so the FIFO really ends up empty
   assign pop = (state == IDLE) & ~bus.empty & ~bus.busy & ~bus.flush;
   always_comb count_nxt = bus.flush ? '0 : bus.count + CW'(wr_ok) - CW'(pop);
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= bus.wr_data;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         bus.count      <= '0;
         bus.empty      <= 1'b1;
         bus.full       <= 1'b0;
         bus.overflow   <= 1'b0;
         bus.p_data     <= '0;
         bus.data_valid <= 1'b0;
      end else begin
         bus.count      <= count_nxt;
         bus.empty      <= count_nxt == '0;
         bus.full       <= count_nxt == CW'(DEPTH);
         bus.overflow   <= bus.wr_en & bus.full & ~bus.flush;
         bus.data_valid <= pop;
         wr_ptr         <= bus.flush ? '0 : wr_ptr + AWIDTH'(wr_ok);
         rd_ptr         <= bus.flush ? '0 : rd_ptr + AWIDTH'(pop);
         if (pop) bus.p_data <= mem[rd_ptr];
         case (state)
            IDLE:      state <= pop ? WAIT_BUSY : IDLE;
            WAIT_BUSY: state <= bus.busy ? WAIT_DONE : WAIT_BUSY;
            default:   state <= bus.busy ? WAIT_DONE : IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: randomized scenarios against a queue model of the FIFO and a uart_tx stand-in
module tb_uart_tx_buffer;
   localparam int FRAME = 6;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic force_busy = 1'b0;
   logic mb = 1'b0;
   logic pend = 1'b0;
   int   left = 0;
   int   dv_count = 0;
   int   total = 0;
   int   bad = 0;
   logic [7:0] rxq[$];
   uart_tx_buffer_if #(.DWIDTH(8), .AWIDTH(4)) bus();
   uart_tx_buffer #(.DWIDTH(8), .DEPTH(16), .AWIDTH(4)) dut(.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   assign bus.busy = force_busy | mb;
   // uart_tx stand-in: captures each issued byte, raises busy two cycles later for FRAME cycles
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mb   <= 1'b0;
         pend <= 1'b0;
         left <= 0;
      end else begin
         pend <= bus.data_valid;
         if (bus.data_valid) begin
            rxq.push_back(bus.p_data);
            dv_count <= dv_count + 1;
         end
         if (pend) begin
            mb   <= 1'b1;
            left <= FRAME;
         end else if (left > 0) begin
            left <= left - 1;
            if (left == 1) mb <= 1'b0;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; bus.wr_en = 1'b0; bus.flush = 1'b0; force_busy = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total += 6;
      if (bus.count !== 5'd0) begin bad++; $display("FAIL rst_count got %0d want 0", bus.count); end
      if (bus.empty !== 1'b1) begin bad++; $display("FAIL rst_empty got %b want 1", bus.empty); end
      if (bus.full !== 1'b0) begin bad++; $display("FAIL rst_full got %b want 0", bus.full); end
      if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got %b want 0", bus.overflow); end
      if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL rst_dv got %b want 0", bus.data_valid); end
      if (bus.p_data !== 8'h00) begin bad++; $display("FAIL rst_pdata got %h want 00", bus.p_data); end
   endtask

   task automatic test_single();
      int base, d0;
      do_reset();
      base = rxq.size(); d0 = dv_count;
      @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
      @(negedge clk); bus.wr_en = 1'b0;
      total += 3;
      if (bus.empty !== 1'b0) begin bad++; $display("FAIL single_empty got %b want 0", bus.empty); end
      if (bus.count !== 5'd1) begin bad++; $display("FAIL single_count1 got %0d want 1", bus.count); end
      if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL single_dv_early got %b want 0", bus.data_valid); end
      @(negedge clk);
      total += 3;
      if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL single_dv got %b want 1", bus.data_valid); end
      if (bus.p_data !== 8'hA5) begin bad++; $display("FAIL single_pdata got %h want a5", bus.p_data); end
      if (bus.count !== 5'd0) begin bad++; $display("FAIL single_count0 got %0d want 0", bus.count); end
      @(negedge clk);
      total++;
      if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL single_dv_width got %b want 0", bus.data_valid); end
      repeat (20) @(negedge clk);
      total += 3;
      if (dv_count - d0 !== 1) begin bad++; $display("FAIL single_issues got %0d want 1", dv_count - d0); end
      if (bus.count !== 5'd0) begin bad++; $display("FAIL single_count_end got %0d want 0", bus.count); end
      if (rxq.size() - base !== 1 || rxq[base] !== 8'hA5) begin bad++; $display("FAIL single_rx got %0d bytes want 1 byte a5", rxq.size() - base); end
   endtask

   task automatic test_full_overflow();
      int base, d0;
      do_reset();
      force_busy = 1'b1;
      base = rxq.size(); d0 = dv_count;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      end
      @(negedge clk);
      total += 3;
      if (bus.full !== 1'b1) begin bad++; $display("FAIL ovf_full got %b want 1", bus.full); end
      if (bus.count !== 5'd16) begin bad++; $display("FAIL ovf_count16 got %0d want 16", bus.count); end
      if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got %b want 0", bus.overflow); end
      bus.wr_data = 8'hFF;
      @(negedge clk); bus.wr_en = 1'b0;
      total += 2;
      if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got %b want 1", bus.overflow); end
      if (bus.count !== 5'd16) begin bad++; $display("FAIL ovf_count_kept got %0d want 16", bus.count); end
      @(negedge clk);
      total++;
      if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_width got %b want 0", bus.overflow); end
      force_busy = 1'b0;
      for (int c = 0; c < 600 && rxq.size() - base < 16; c++) @(negedge clk);
      repeat (20) @(negedge clk);
      total += 2;
      if (rxq.size() - base !== 16) begin bad++; $display("FAIL ovf_rx_n got %0d want 16", rxq.size() - base); end
      if (dv_count - d0 !== 16) begin bad++; $display("FAIL ovf_issues got %0d want 16", dv_count - d0); end
      for (int i = 0; i < 16 && base + i < rxq.size(); i++) begin
         total++;
         if (rxq[base + i] !== 8'(i + 1)) begin bad++; $display("FAIL ovf_order[%0d] got %h want %h", i, rxq[base + i], 8'(i + 1)); end
      end
   endtask

   task automatic test_simultaneous();
      int base;
      logic [7:0] exp[$];
      logic [7:0] b;
      do_reset();
      force_busy = 1'b1;
      base = rxq.size();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); b = 8'($urandom); bus.wr_en = 1'b1; bus.wr_data = b; exp.push_back(b);
      end
      @(negedge clk);
      total++;
      if (bus.count !== 5'd5) begin bad++; $display("FAIL simul_count_pre got %0d want 5", bus.count); end
      force_busy = 1'b0;
      b = 8'($urandom); bus.wr_data = b; exp.push_back(b);
      @(negedge clk); bus.wr_en = 1'b0;
      total += 3;
      if (bus.count !== 5'd5) begin bad++; $display("FAIL simul_count got %0d want 5", bus.count); end
      if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL simul_dv got %b want 1", bus.data_valid); end
      if (bus.p_data !== exp[0]) begin bad++; $display("FAIL simul_pdata got %h want %h", bus.p_data, exp[0]); end
      for (int c = 0; c < 400 && rxq.size() - base < 6; c++) @(negedge clk);
      total++;
      if (rxq.size() - base !== 6) begin bad++; $display("FAIL simul_rx_n got %0d want 6", rxq.size() - base); end
      for (int i = 0; i < 6 && base + i < rxq.size(); i++) begin
         total++;
         if (rxq[base + i] !== exp[i]) begin bad++; $display("FAIL simul_order[%0d] got %h want %h", i, rxq[base + i], exp[i]); end
      end
   endtask

   task automatic test_flush();
      int base, d0;
      logic [7:0] b0;
      do_reset();
      force_busy = 1'b1;
      base = rxq.size(); d0 = dv_count;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = 8'($urandom);
         if (i == 0) b0 = bus.wr_data;
      end
      @(negedge clk); bus.wr_en = 1'b0; force_busy = 1'b0;
      for (int c = 0; c < 50 && !mb; c++) @(negedge clk);
      total += 2;
      if (mb !== 1'b1) begin bad++; $display("FAIL flush_inflight got %b want 1", mb); end
      if (bus.count !== 5'd8) begin bad++; $display("FAIL flush_count_pre got %0d want 8", bus.count); end
      bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'($urandom);
      @(negedge clk); bus.flush = 1'b0; bus.wr_en = 1'b0;
      total += 4;
      if (bus.count !== 5'd0) begin bad++; $display("FAIL flush_count got %0d want 0", bus.count); end
      if (bus.empty !== 1'b1) begin bad++; $display("FAIL flush_empty got %b want 1", bus.empty); end
      if (bus.full !== 1'b0) begin bad++; $display("FAIL flush_full got %b want 0", bus.full); end
      if (bus.overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf got %b want 0", bus.overflow); end
      @(negedge clk);
      total++;
      if (bus.overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf2 got %b want 0", bus.overflow); end
      repeat (40) @(negedge clk);
      total += 3;
      if (dv_count - d0 !== 1) begin bad++; $display("FAIL flush_issues got %0d want 1", dv_count - d0); end
      if (rxq.size() - base !== 1 || rxq[base] !== b0) begin bad++; $display("FAIL flush_rx got %0d bytes want 1 byte %h", rxq.size() - base, b0); end
      if (mb !== 1'b0) begin bad++; $display("FAIL flush_frame_done got %b want 0", mb); end
   endtask

   task automatic test_reset_midframe();
      int d0;
      do_reset();
      force_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = 8'h11 * 8'(i + 1);
      end
      @(negedge clk); bus.wr_en = 1'b0; force_busy = 1'b0;
      for (int c = 0; c < 50 && !mb; c++) @(negedge clk);
      total += 2;
      if (mb !== 1'b1) begin bad++; $display("FAIL rmid_inflight got %b want 1", mb); end
      if (bus.p_data !== 8'h11) begin bad++; $display("FAIL rmid_pdata_pre got %h want 11", bus.p_data); end
      #2 rst = 1'b0;
      #1;
      total += 5;
      if (bus.count !== 5'd0) begin bad++; $display("FAIL rmid_count got %0d want 0", bus.count); end
      if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL rmid_dv got %b want 0", bus.data_valid); end
      if (bus.p_data !== 8'h00) begin bad++; $display("FAIL rmid_pdata got %h want 00", bus.p_data); end
      if (bus.empty !== 1'b1) begin bad++; $display("FAIL rmid_empty got %b want 1", bus.empty); end
      if (bus.full !== 1'b0) begin bad++; $display("FAIL rmid_full got %b want 0", bus.full); end
      @(negedge clk); rst = 1'b1;
      d0 = dv_count;
      repeat (20) @(negedge clk);
      total++;
      if (dv_count - d0 !== 0) begin bad++; $display("FAIL rmid_no_issue got %0d want 0", dv_count - d0); end
   endtask

   task automatic test_wrap();
      int base, sent, ovf;
      logic [7:0] exp[$];
      logic [7:0] b;
      do_reset();
      base = rxq.size(); sent = 0; ovf = 0;
      for (int c = 0; c < 6000 && (sent < 40 || rxq.size() - base < 40); c++) begin
         @(negedge clk);
         if (bus.overflow !== 1'b0) ovf++;
         if (sent < 40 && !bus.full && $urandom_range(0, 3) != 0) begin
            b = 8'($urandom); bus.wr_en = 1'b1; bus.wr_data = b; exp.push_back(b); sent++;
         end else bus.wr_en = 1'b0;
      end
      bus.wr_en = 1'b0;
      repeat (20) @(negedge clk);
      total += 3;
      if (ovf !== 0) begin bad++; $display("FAIL wrap_overflow got %0d pulses want 0", ovf); end
      if (rxq.size() - base !== 40) begin bad++; $display("FAIL wrap_rx_n got %0d want 40", rxq.size() - base); end
      if (bus.count !== 5'd0) begin bad++; $display("FAIL wrap_count_end got %0d want 0", bus.count); end
      for (int i = 0; i < 40 && base + i < rxq.size(); i++) begin
         total++;
         if (rxq[base + i] !== exp[i]) begin bad++; $display("FAIL wrap_order[%0d] got %h want %h", i, rxq[base + i], exp[i]); end
      end
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.flush = 1'b0;
      test_reset();
      test_single();
      test_full_overflow();
      test_simultaneous();
      test_flush();
      test_reset_midframe();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO and issue controller placed directly upstream of `uart_tx`. Accepts bytes from the host at any rate up to one per cycle and stores up to `DEPTH` of them. Presents them to `uart_tx` one at a time through `p_data`/`data_valid`, using the transmitter's `busy` output for flow control. Runs in the transmitter clock domain (`clk_tx` at the `uart` level).

## Interface
- `DWIDTH`, 8, data byte width; matches `uart_tx`
- `DEPTH`, 16, FIFO entries; power of two, at least 2
- `AWIDTH`, 4, log2(`DEPTH`)
- `clk`  in  1  transmitter clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wr_data`  in  DWIDTH  host byte
- `wr_en`  in  1  host write strobe
- `flush`  in  1  synchronous FIFO clear
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `count`  out  AWIDTH+1  bytes stored; excludes any byte already issued
- `overflow`  out  1  one-cycle pulse when a write is dropped
- `p_data`  out  DWIDTH  byte to `uart_tx`
- `data_valid`  out  1  one-cycle issue strobe to `uart_tx`
- `busy`  in  1  from `uart_tx`; high while a frame is in progress

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr` (AWIDTH bits each, wrapping naturally) and a registered `count`. `full` and `empty` are registered and derived from the next value of `count`.
- Write: when `wr_en` is high, `full` is low and `flush` is low, store `wr_data` at `mem[wr_ptr]` and increment `wr_ptr`.
  - If `wr_en` is high and `full` is high, drop the byte and pulse `overflow` high on the next cycle.
  - `full` is evaluated before any pop in the same cycle, so a write into a full FIFO is dropped even while a pop occurs.
- Issue FSM has three states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if `empty` is low and `busy` is low, then at the edge:
    - `p_data` <= `mem[rd_ptr]`
    - `data_valid` <= 1
    - `rd_ptr` increments and `count` decrements
    - state <= WAIT_BUSY
  - In every other cycle, `data_valid` <= 0.
  - WAIT_BUSY: when `busy` is 1, go to WAIT_DONE. No re-issue is allowed here, even though `busy` is still low.
  - WAIT_DONE: when `busy` is 0, go to IDLE.
- Simultaneous write and pop: `count` is unchanged and both pointers advance.
- Flush: `rd_ptr`, `wr_ptr` and `count` go to 0, `empty` goes to 1, `full` goes to 0.
  - Flush does not alter FSM state, `p_data` or `data_valid`, so a byte already issued still completes.
  - Flush wins over a simultaneous write: the write is dropped with no `overflow`.
  - A pop in the same cycle as a flush is suppressed.
- `p_data` holds the last issued byte until the next issue.

## Timing
- Values on reset (asynchronous, `rst`=0):
  - `p_data` = 0, `data_valid` = 0
  - `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0
  - pointers = 0, state = IDLE
  - `mem` contents are not reset.
- Reset asserted mid-frame aborts the FIFO state immediately. `uart_tx` shares the reset.
- Write-to-issue latency: `wr_en` sampled at edge N into an empty FIFO in IDLE gives `empty`=0 after N, and `data_valid`=1 with `p_data` valid during cycle N+1 to N+2.
- `data_valid` is exactly one cycle wide.
- `uart_tx` samples it at the following edge and raises `busy` no later than one cycle after that.
- Minimum spacing between issues: `busy` falls, the FSM reaches IDLE on the next edge, and it issues on the edge after that. There are at least 2 idle cycles between the end of `busy` and the next `data_valid`.
- `count` and `full`/`empty` update on the same edge as the pointer change.

## Test plan
- Reset, then write 0xA5 once with `busy` held low and raised 2 cycles after `data_valid` for 20 cycles.
  - Expect `data_valid` pulse 2 cycles after the write with `p_data`=0xA5.
  - `count` returns to 0 and no second issue occurs.
- Write 0x01..0x10 back-to-back (16 bytes) while `busy`=1 throughout.
  - `full`=1 after the 16th write.
  - A 17th write of 0xFF pulses `overflow` and does not change `count` (16).
  - After releasing `busy`, output order is 0x01..0x10.
- At count=5, assert `wr_en` on the same cycle as an issue.
  - `count` stays 5 and the written byte is emitted last.
- At count=8 with a frame in flight, assert `flush` together with `wr_en`.
  - `count`=0, `empty`=1, no `overflow`.
  - The in-flight frame finishes and no further `data_valid` appears.
- Fill with 3 bytes, then drop `rst` to 0 for 1 cycle mid-frame.
  - All outputs go immediately to reset values: `count`=0, `data_valid`=0, `p_data`=0.
- Pointer wrap: stream 40 bytes with random `wr_en` gaps and a `uart_tx` model.
  - All 40 bytes are received in order.
  - `overflow` never pulses when writes are gated by `full`.
